// File: rtl/fsm_pattern_sequencer.sv
// Run controller for the serial detector FSM: resets it, shifts a pattern in,
// and collects the per-bit Moore response plus its population count.
module fsm_pattern_sequencer #(
    parameter int N_BITS    = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [N_BITS-1:0]           pattern,
    input  logic                        abort,
    input  logic                        d_in,
    output logic                        s_out,
    output logic                        fsm_rst,
    output logic                        busy,
    output logic                        done,
    output logic                        aborted,
    output logic [N_BITS-1:0]           response,
    output logic [$clog2(N_BITS+1)-1:0] ones_cnt
);

    localparam int CW = $clog2(N_BITS + 1);
    localparam int KW = $clog2(N_BITS);
    localparam logic [KW-1:0] KLAST = KW'(N_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        DRIVE = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [N_BITS-1:0]   pat_q, pat_d;
    logic [N_BITS-1:0]   resp_q, resp_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                abt_q, abt_d;
    logic                s_out_q, s_out_d;
    logic                frst_q, frst_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                samp;
    logic [KW-1:0]       samp_idx;
    logic [KW-1:0]       sel;
    logic                bad;
    logic                run;

    assign run = (state_q == CLR) || (state_q == DRIVE) ||
                 (state_q == FLUSH);

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        pat_d    = pat_q;
        resp_d   = resp_q;
        cnt_d    = cnt_q;
        abt_d    = abt_q;
        samp     = 1'b0;
        samp_idx = '0;
        bad      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLR;
                    pat_d   = pattern;
                    resp_d  = '0;
                    cnt_d   = '0;
                    abt_d   = 1'b0;
                end
            end
            CLR: begin
                state_d = DRIVE;
                k_d     = '0;
            end
            DRIVE: begin
                // d_in lags the driven bit by one cycle
                samp     = (k_q != '0);
                samp_idx = k_q - 1'b1;
                if (k_q == KLAST) begin
                    state_d = FLUSH;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            FLUSH: begin
                samp     = 1'b1;
                samp_idx = KLAST;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
                pat_d   = '0;
                resp_d  = '0;
                cnt_d   = '0;
                abt_d   = 1'b0;
                bad     = 1'b1;
            end
        endcase

        if (samp) begin
            resp_d[samp_idx] = d_in;
            cnt_d = cnt_q + CW'(d_in);
        end

        if (abort && run) begin
            state_d = IDLE;
            abt_d   = 1'b1;
        end
    end

    // Outputs are registered from the next state
    always_comb begin
        sel     = LSB_FIRST ? k_d : (KLAST - k_d);
        s_out_d = (state_d == DRIVE) ? pat_d[sel] : 1'b0;
        frst_d  = (state_d == CLR) || bad;
        busy_d  = (state_d == CLR) || (state_d == DRIVE) ||
                  (state_d == FLUSH);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            pat_q   <= '0;
            resp_q  <= '0;
            cnt_q   <= '0;
            abt_q   <= 1'b0;
            s_out_q <= 1'b0;
            frst_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            pat_q   <= pat_d;
            resp_q  <= resp_d;
            cnt_q   <= cnt_d;
            abt_q   <= abt_d;
            s_out_q <= s_out_d;
            frst_q  <= frst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign s_out    = s_out_q;
    assign fsm_rst  = frst_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign aborted  = abt_q;
    assign response = resp_q;
    assign ones_cnt = cnt_q;

endmodule

// File: tb/tb_fsm_pattern_sequencer.sv
// Bench for fsm_pattern_sequencer: both shift orders, each driving its own
// behavioural model of the a/b/c/d detector FSM.
module tb_fsm_pattern_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] pattern;

    logic       l_sout, l_frst, l_busy, l_done, l_abt, l_din;
    logic [7:0] l_resp;
    logic [3:0] l_cnt;
    logic       m_sout, m_frst, m_busy, m_done, m_abt, m_din;
    logic [7:0] m_resp;
    logic [3:0] m_cnt;

    always #5 clk = ~clk;

    fsm_pattern_sequencer #(.N_BITS(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern),
        .abort(abort), .d_in(l_din), .s_out(l_sout),
        .fsm_rst(l_frst), .busy(l_busy), .done(l_done),
        .aborted(l_abt), .response(l_resp), .ones_cnt(l_cnt)
    );

    fsm_pattern_sequencer #(.N_BITS(8), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern),
        .abort(abort), .d_in(m_din), .s_out(m_sout),
        .fsm_rst(m_frst), .busy(m_busy), .done(m_done),
        .aborted(m_abt), .response(m_resp), .ones_cnt(m_cnt)
    );

    typedef enum logic [1:0] {SA, SB, SC, SD} fst_e;

    function automatic fst_e nxt(fst_e s, logic x);
        case (s)
            SA:      return x ? SA : SD;
            SB:      return x ? SA : SC;
            SC:      return x ? SD : SB;
            default: return x ? SD : SC;
        endcase
    endfunction

    fst_e l_st = SA;
    fst_e m_st = SA;

    always_ff @(posedge clk) begin
        l_st <= l_frst ? SA : nxt(l_st, l_sout);
        m_st <= m_frst ? SA : nxt(m_st, m_sout);
    end

    assign l_din = (l_st == SB) || (l_st == SC);
    assign m_din = (m_st == SB) || (m_st == SC);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!l_done && lat < 30) begin
            step();
            lat++;
        end
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_sout"}, l_sout, 0);
        chk({tag, "_frst"}, l_frst, 1);
        chk({tag, "_busy"}, l_busy, 0);
        chk({tag, "_done"}, l_done, 0);
        chk({tag, "_abt"}, l_abt, 0);
        chk({tag, "_resp"}, l_resp, 0);
        chk({tag, "_cnt"}, l_cnt, 0);
    endtask

    typedef struct {
        logic [7:0] pat;
        logic [7:0] l_resp;
        logic [3:0] l_cnt;
        logic [7:0] m_resp;
        logic [3:0] m_cnt;
    } vec_t;

    vec_t tv[5];

    initial begin
        int lat;
        int nd;

        tv[0] = '{8'hFF, 8'h00, 4'd0, 8'h00, 4'd0};
        tv[1] = '{8'h00, 8'hFE, 4'd7, 8'hFE, 4'd7};
        tv[2] = '{8'h55, 8'hA8, 4'd3, 8'h54, 4'd3};
        tv[3] = '{8'hAA, 8'h54, 4'd3, 8'hA8, 4'd3};
        tv[4] = '{8'h0F, 8'hE0, 4'd3, 8'h0E, 4'd3};

        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        pattern = 8'h00;
        step();
        step();
        chk_reset_vals("rst");
        rst = 1'b0;
        step();
        chk("idle_frst", l_frst, 0);

        for (int i = 0; i < 5; i++) begin
            pattern = tv[i].pat;
            start = 1'b1;
            step();
            start = 1'b0;
            chk($sformatf("v%0d_clr_busy", i), l_busy, 1);
            chk($sformatf("v%0d_clr_frst", i), l_frst, 1);
            wait_done(lat);
            chk($sformatf("v%0d_lat", i), lat, 11);
            chk($sformatf("v%0d_mdone", i), m_done, 1);
            chk($sformatf("v%0d_lresp", i), l_resp, tv[i].l_resp);
            chk($sformatf("v%0d_lcnt", i), l_cnt, tv[i].l_cnt);
            chk($sformatf("v%0d_mresp", i), m_resp, tv[i].m_resp);
            chk($sformatf("v%0d_mcnt", i), m_cnt, tv[i].m_cnt);
            step();
            chk($sformatf("v%0d_pulse", i), l_done, 0);
            chk($sformatf("v%0d_hold", i), l_resp, tv[i].l_resp);
        end

        pattern = 8'h00;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abt_busy", l_busy, 0);
        chk("abt_flag", l_abt, 1);
        chk("abt_resp", l_resp, 8'h06);
        chk("abt_cnt", l_cnt, 2);
        chk("abt_sout", l_sout, 0);
        chk("abt_frst", l_frst, 0);
        nd = 0;
        repeat (15) begin
            step();
            if (l_done) nd++;
        end
        chk("abt_nodone", nd, 0);
        chk("abt_sticky", l_abt, 1);
        chk("abt_held", l_resp, 8'h06);

        pattern = 8'hFF;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("restart_busy", l_busy, 1);
        chk("restart_abt", l_abt, 0);
        wait_done(lat);
        chk("restart_lat", lat, 11);
        chk("restart_resp", l_resp, 8'h00);
        step();

        pattern = 8'h00;
        start = 1'b1;
        step();
        lat = 1;
        while (!l_done && lat < 30) begin
            if (lat == 4) pattern = 8'hFF;
            step();
            lat++;
        end
        chk("hold_lat", lat, 11);
        chk("hold_resp", l_resp, 8'hFE);
        chk("hold_cnt", l_cnt, 7);
        step();
        chk("hold_gap_done", l_done, 0);
        chk("hold_gap_busy", l_busy, 0);
        step();
        start = 1'b0;
        chk("hold_2nd_busy", l_busy, 1);
        chk("hold_2nd_frst", l_frst, 1);
        wait_done(lat);
        chk("hold_2nd_lat", lat, 11);
        chk("hold_2nd_resp", l_resp, 8'h00);
        step();

        pattern = 8'h00;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_vals("midrst");
        nd = 0;
        repeat (15) begin
            step();
            if (l_done) nd++;
        end
        chk("midrst_nodone", nd, 0);
        chk("midrst_frst", l_frst, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
